// File: rtl/rv32i_control_fsm_if.sv
// Control bundle between the RV32I multi-cycle sequencer and its datapath.
// The sequencer is the master: it consumes the instruction word, the branch
// comparator flags and the memory handshake, and drives every select/enable.
interface rv32i_control_fsm_if;
  logic [31:0] instr;
  logic        br_eq;
  logic        br_lt;
  logic        dmem_ready;

  logic        IRWrite;
  logic        PCWrite;
  logic        PCSel;
  logic        RegWEn;
  logic        ASel;
  logic        BSel;
  logic [3:0]  ALUSel;
  logic [2:0]  ImmSel;
  logic        BrUn;
  logic [1:0]  WBSel;
  logic        MemReq;
  logic        MemRW;
  logic        illegal;
  logic [31:0] instret;

  modport master (
    input  instr, br_eq, br_lt, dmem_ready,
    output IRWrite, PCWrite, PCSel, RegWEn, ASel, BSel, ALUSel, ImmSel,
           BrUn, WBSel, MemReq, MemRW, illegal, instret
  );

  modport slave (
    output instr, br_eq, br_lt, dmem_ready,
    input  IRWrite, PCWrite, PCSel, RegWEn, ASel, BSel, ALUSel, ImmSel,
           BrUn, WBSel, MemReq, MemRW, illegal, instret
  );
endinterface

// File: rtl/rv32i_control_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with a sticky
// TRAP for unsupported encodings. Outputs are decoded from state + instr and
// forced low while rst is high; instret counts cycles with PCWrite asserted.
module rv32i_control_fsm (
  input  logic                 clk,
  input  logic                 rst,
  rv32i_control_fsm_if.master  bus
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_IMM    = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111
  } opcode_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_t;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_t;

  state_t      state;
  logic [31:0] count;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;

  assign opcode = bus.instr[6:0];
  assign rd     = bus.instr[11:7];
  assign funct3 = bus.instr[14:12];
  assign funct7 = bus.instr[31:25];

  logic is_load, is_store, is_branch, is_jump, legal, taken;
  logic a_sel, b_sel;
  alu_t alu_sel;
  alu_t arith;
  imm_t imm_sel;

  logic ir_write, pc_write, pc_sel, reg_wen, br_un, mem_req, mem_rw, trap;
  logic [1:0] wb_sel;

  // Instruction decode: class flags, legality and the EXEC-phase ALU setup.
  always_comb begin
    case (funct3)
      3'b000:  arith = (opcode == OP_R && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  arith = ALU_SLL;
      3'b010:  arith = ALU_SLT;
      3'b011:  arith = ALU_SLTU;
      3'b100:  arith = ALU_XOR;
      3'b101:  arith = funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  arith = ALU_OR;
      default: arith = ALU_AND;
    endcase

    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    legal     = 1'b1;
    a_sel     = 1'b0;
    b_sel     = 1'b1;
    alu_sel   = ALU_ADD;
    imm_sel   = IMM_I;
    case (opcode)
      OP_R: begin
        b_sel   = 1'b0;
        alu_sel = arith;
        legal   = (funct7 == 7'b0000000) ||
                  (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
      end
      OP_IMM:   alu_sel = arith;
      OP_LOAD:  is_load = 1'b1;
      OP_STORE: begin
        is_store = 1'b1;
        imm_sel  = IMM_S;
      end
      OP_BRANCH: begin
        is_branch = 1'b1;
        a_sel     = 1'b1;
        imm_sel   = IMM_B;
        legal     = (funct3[2:1] != 2'b01);
      end
      OP_JAL: begin
        is_jump = 1'b1;
        a_sel   = 1'b1;
        imm_sel = IMM_J;
      end
      OP_JALR:  is_jump = 1'b1;
      OP_LUI: begin
        alu_sel = ALU_PASSB;
        imm_sel = IMM_U;
      end
      OP_AUIPC: begin
        a_sel   = 1'b1;
        imm_sel = IMM_U;
      end
      default: begin
        legal = 1'b0;
        b_sel = 1'b0;
      end
    endcase

    // funct3[0] inverts the sense: BNE/BGE/BGEU are the complements.
    taken = funct3[2] ? (bus.br_lt ^ funct3[0]) : (bus.br_eq ^ funct3[0]);
  end

  // Per-state control outputs; EXEC ALU setup stays on through MEM and WB.
  always_comb begin
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    reg_wen  = 1'b0;
    br_un    = 1'b0;
    mem_req  = 1'b0;
    mem_rw   = 1'b0;
    trap     = 1'b0;
    wb_sel   = 2'd0;
    case (state)
      FETCH:  ir_write = 1'b1;
      DECODE: ;
      EXEC: begin
        if (is_branch) begin
          pc_write = 1'b1;
          pc_sel   = taken;
          br_un    = (funct3[2:1] == 2'b11);
        end
      end
      MEM: begin
        mem_req  = 1'b1;
        mem_rw   = is_store;
        pc_write = is_store && bus.dmem_ready;
      end
      WB: begin
        reg_wen  = (rd != 5'd0);
        wb_sel   = is_load ? 2'd1 : (is_jump ? 2'd2 : 2'd0);
        pc_write = 1'b1;
        pc_sel   = is_jump;
      end
      default: trap = 1'b1;
    endcase
  end

  wire alu_phase = (state == EXEC) || (state == MEM) || (state == WB);

  assign bus.IRWrite = ir_write & ~rst;
  assign bus.PCWrite = pc_write & ~rst;
  assign bus.PCSel   = pc_sel & ~rst;
  assign bus.RegWEn  = reg_wen & ~rst;
  assign bus.ASel    = a_sel & alu_phase & ~rst;
  assign bus.BSel    = b_sel & alu_phase & ~rst;
  assign bus.ALUSel  = (alu_phase && !rst) ? alu_sel : 4'd0;
  assign bus.ImmSel  = ((alu_phase || state == DECODE) && !rst) ? imm_sel : 3'd0;
  assign bus.BrUn    = br_un & ~rst;
  assign bus.WBSel   = rst ? 2'd0 : wb_sel;
  assign bus.MemReq  = mem_req & ~rst;
  assign bus.MemRW   = mem_rw & ~rst;
  assign bus.illegal = trap & ~rst;
  assign bus.instret = rst ? '0 : count;

  // Sequencer state and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      count <= '0;
    end else begin
      count <= count + {31'd0, pc_write};
      case (state)
        FETCH:  state <= DECODE;
        DECODE: state <= legal ? EXEC : TRAP;
        EXEC: begin
          if (is_load || is_store) state <= MEM;
          else if (is_branch)      state <= FETCH;
          else                     state <= WB;
        end
        MEM: begin
          if (bus.dmem_ready) state <= is_store ? FETCH : WB;
        end
        WB:      state <= FETCH;
        TRAP:    state <= TRAP;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_control_fsm.sv
// Directed bench for rv32i_control_fsm: steps hand-encoded instructions and
// compares the full control vector every cycle against hand-derived values.
module tb_rv32i_control_fsm;

  typedef struct packed {
    logic       ir;
    logic       pcw;
    logic       pcs;
    logic       rwe;
    logic       asel;
    logic       bsel;
    logic [3:0] alu;
    logic [2:0] imm;
    logic       brun;
    logic [1:0] wb;
    logic       mreq;
    logic       mrw;
    logic       ill;
  } ctl_t;

  localparam ctl_t Z = '0;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] exp_ret;
  ctl_t obs;

  rv32i_control_fsm_if bus ();

  rv32i_control_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always_comb obs = {bus.IRWrite, bus.PCWrite, bus.PCSel, bus.RegWEn, bus.ASel,
                     bus.BSel, bus.ALUSel, bus.ImmSel, bus.BrUn, bus.WBSel,
                     bus.MemReq, bus.MemRW, bus.illegal};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Check the control vector in the current cycle, then advance one cycle.
  task automatic cyc(input string tag, input ctl_t e);
    @(negedge clk);
    check(tag, 32'(obs), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic check_ret(input string tag);
    check(tag, bus.instret, exp_ret);
  endtask

  initial begin
    rst            = 1'b1;
    bus.instr      = 32'h0;
    bus.br_eq      = 1'b0;
    bus.br_lt      = 1'b0;
    bus.dmem_ready = 1'b0;
    exp_ret        = 32'd0;
    @(posedge clk);
    #1;
    check_ret("rst_instret");
    cyc("rst_ctl", Z);
    rst = 1'b0;

    // ADD x3,x1,x2
    bus.instr = 32'h002081B3;
    cyc("add_f", ctl_t'{ir: 1'b1, default: '0});
    cyc("add_d", Z);
    cyc("add_e", Z);
    check_ret("add_ret_before");
    cyc("add_w", ctl_t'{rwe: 1'b1, pcw: 1'b1, default: '0});
    exp_ret = 32'd1;
    check_ret("add_ret");

    // LW x5,8(x1) with three wait cycles
    bus.instr = 32'h0080A283;
    cyc("lw_f", ctl_t'{ir: 1'b1, default: '0});
    cyc("lw_d", Z);
    cyc("lw_e", ctl_t'{bsel: 1'b1, default: '0});
    for (int i = 0; i < 3; i++)
      cyc("lw_mem_wait", ctl_t'{bsel: 1'b1, mreq: 1'b1, default: '0});
    bus.dmem_ready = 1'b1;
    cyc("lw_mem_rdy", ctl_t'{bsel: 1'b1, mreq: 1'b1, default: '0});
    bus.dmem_ready = 1'b0;
    cyc("lw_wb", ctl_t'{bsel: 1'b1, rwe: 1'b1, wb: 2'd1, pcw: 1'b1, default: '0});
    exp_ret = 32'd2;
    check_ret("lw_ret");

    // BEQ taken / not taken, BLTU taken, BGE not taken
    bus.instr = 32'h00208463;
    bus.br_eq = 1'b1;
    cyc("beq_f", ctl_t'{ir: 1'b1, default: '0});
    cyc("beq_d", ctl_t'{imm: 3'd2, default: '0});
    cyc("beq_e_taken", ctl_t'{asel: 1'b1, bsel: 1'b1, imm: 3'd2, pcw: 1'b1, pcs: 1'b1, default: '0});
    exp_ret = 32'd3;
    check_ret("beq_ret");
    bus.br_eq = 1'b0;
    cyc("beq2_f", ctl_t'{ir: 1'b1, default: '0});
    cyc("beq2_d", ctl_t'{imm: 3'd2, default: '0});
    cyc("beq_e_not", ctl_t'{asel: 1'b1, bsel: 1'b1, imm: 3'd2, pcw: 1'b1, default: '0});
    bus.instr = 32'h0020E463;
    bus.br_lt = 1'b1;
    cyc("bltu_f", ctl_t'{ir: 1'b1, default: '0});
    cyc("bltu_d", ctl_t'{imm: 3'd2, default: '0});
    cyc("bltu_e", ctl_t'{asel: 1'b1, bsel: 1'b1, imm: 3'd2, pcw: 1'b1, pcs: 1'b1, brun: 1'b1, default: '0});
    bus.instr = 32'h0020D463;
    cyc("bge_f", ctl_t'{ir: 1'b1, default: '0});
    cyc("bge_d", ctl_t'{imm: 3'd2, default: '0});
    cyc("bge_e", ctl_t'{asel: 1'b1, bsel: 1'b1, imm: 3'd2, pcw: 1'b1, default: '0});
    bus.br_lt = 1'b0;
    exp_ret = 32'd6;
    check_ret("branch_ret");

    // JALR x1,0(x1)
    bus.instr = 32'h000080E7;
    cyc("jalr_f", ctl_t'{ir: 1'b1, default: '0});
    cyc("jalr_d", Z);
    cyc("jalr_e", ctl_t'{bsel: 1'b1, default: '0});
    cyc("jalr_w", ctl_t'{bsel: 1'b1, rwe: 1'b1, wb: 2'd2, pcw: 1'b1, pcs: 1'b1, default: '0});

    // ADDI x0,x0,0: no register write
    bus.instr = 32'h00000013;
    cyc("nop_f", ctl_t'{ir: 1'b1, default: '0});
    cyc("nop_d", Z);
    cyc("nop_e", ctl_t'{bsel: 1'b1, default: '0});
    cyc("nop_w", ctl_t'{bsel: 1'b1, pcw: 1'b1, default: '0});

    // SUB x3,x1,x2 and SRAI x3,x1,4
    bus.instr = 32'h402081B3;
    cyc("sub_f", ctl_t'{ir: 1'b1, default: '0});
    cyc("sub_d", Z);
    cyc("sub_e", ctl_t'{alu: 4'd1, default: '0});
    cyc("sub_w", ctl_t'{alu: 4'd1, rwe: 1'b1, pcw: 1'b1, default: '0});
    bus.instr = 32'h4040D193;
    cyc("srai_f", ctl_t'{ir: 1'b1, default: '0});
    cyc("srai_d", Z);
    cyc("srai_e", ctl_t'{bsel: 1'b1, alu: 4'd7, default: '0});
    cyc("srai_w", ctl_t'{bsel: 1'b1, alu: 4'd7, rwe: 1'b1, pcw: 1'b1, default: '0});
    exp_ret = 32'd10;
    check_ret("alu_ret");

    // SW x2,0(x1) with memory ready immediately
    bus.instr      = 32'h0020A023;
    bus.dmem_ready = 1'b1;
    cyc("sw_f", ctl_t'{ir: 1'b1, default: '0});
    cyc("sw_d", ctl_t'{imm: 3'd1, default: '0});
    cyc("sw_e", ctl_t'{bsel: 1'b1, imm: 3'd1, default: '0});
    cyc("sw_mem", ctl_t'{bsel: 1'b1, imm: 3'd1, mreq: 1'b1, mrw: 1'b1, pcw: 1'b1, default: '0});
    bus.dmem_ready = 1'b0;
    exp_ret = 32'd11;
    check_ret("sw_ret");

    // SW again, reset while stalled in MEM
    cyc("sw2_f", ctl_t'{ir: 1'b1, default: '0});
    cyc("sw2_d", ctl_t'{imm: 3'd1, default: '0});
    cyc("sw2_e", ctl_t'{bsel: 1'b1, imm: 3'd1, default: '0});
    cyc("sw2_mem", ctl_t'{bsel: 1'b1, imm: 3'd1, mreq: 1'b1, mrw: 1'b1, default: '0});
    rst = 1'b1;
    cyc("sw_rst_ctl", Z);
    exp_ret = 32'd0;
    check_ret("sw_rst_instret");
    cyc("sw_rst_ctl2", Z);
    rst = 1'b0;
    check_ret("post_rst_instret");

    // Illegal opcode: sticky trap until reset
    bus.instr = 32'h0000007F;
    cyc("ill_f", ctl_t'{ir: 1'b1, default: '0});
    cyc("ill_d", Z);
    for (int i = 0; i < 20; i++)
      cyc("ill_trap", ctl_t'{ill: 1'b1, default: '0});
    check_ret("ill_ret");
    rst = 1'b1;
    cyc("ill_rst", Z);
    rst = 1'b0;

    // R-type with unsupported funct7 traps as well
    bus.instr = 32'h022081B3;
    cyc("mul_f", ctl_t'{ir: 1'b1, default: '0});
    cyc("mul_d", Z);
    cyc("mul_trap", ctl_t'{ill: 1'b1, default: '0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
